// File: rtl/ram_bridge_pkg.sv
// Shared types and helpers for the Wishbone-to-ram32 bridge.
package ram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    ACK   = 3'd4
  } state_t;

  localparam logic [3:0] SEL_FULL = 4'hF;

  // Lanes whose select bit is set take the new data; the rest keep the old word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    for (int n = 0; n < 4; n++) begin
      merged[8*n +: 8] = sel[n] ? new_word[8*n +: 8] : old_word[8*n +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram32.sv
// 32-bit single-port on-chip RAM with one cycle of read latency.
module ram32 #(
  parameter  int RAM_SIZE = 1024,
  localparam int AW       = $clog2(RAM_SIZE / 4)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [31:0]   data_in,
  output logic [31:0]   data_out
);

  logic [31:0] mem [RAM_SIZE/4];

  // NOTE: the storage array is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) data_out <= '0;
    else       data_out <= mem[addr];
  end

endmodule

// File: rtl/wb_ram32_bridge.sv
// Wishbone classic slave in front of ram32; partial writes become read-modify-write.
module wb_ram32_bridge
  import ram_bridge_pkg::*;
#(
  parameter  int RAM_SIZE      = 1024,
  localparam int RAM_ADDR_BITS = $clog2(RAM_SIZE / 4)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [31:0]              i_wb_adr,
  input  logic [31:0]              i_wb_dat,
  input  logic [3:0]               i_wb_sel,
  output logic [31:0]              o_wb_rdt,
  output logic                     o_wb_ack,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic                     ram_we,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata
);

  state_t                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] addr_q,  addr_d;
  logic [31:0]              dat_q,   dat_d;
  logic [3:0]               sel_q,   sel_d;
  logic                     we_q,    we_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [31:0]              rdt_q,   rdt_d;

  // Address bits outside the RAM word index alias silently.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{i_wb_adr[31:RAM_ADDR_BITS+2], i_wb_adr[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdt_q   <= rdt_d;
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdt_d   = rdt_q;

    unique case (state_q)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          addr_d  = i_wb_adr[RAM_ADDR_BITS+1:2];
          dat_d   = i_wb_dat;
          sel_d   = i_wb_sel;
          we_d    = i_wb_we;
          wdata_d = i_wb_dat;
          if (!i_wb_we || (i_wb_sel != SEL_FULL && i_wb_sel != 4'h0)) state_d = READ;
          else if (i_wb_sel == SEL_FULL)                             state_d = WRITE;
          else                                                       state_d = ACK;
        end
      end
      READ: begin
        state_d = i_wb_cyc ? WAIT : IDLE;
      end
      WAIT: begin
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end else if (!we_q) begin
          rdt_d   = ram_rdata;
          state_d = ACK;
        end else begin
          wdata_d = byte_merge(ram_rdata, dat_q, sel_q);
          state_d = WRITE;
        end
      end
      WRITE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // wdata_q holds the full write word, or the merged word after a partial-write read.
  assign ram_we    = (state_q == WRITE);
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign o_wb_ack  = (state_q == ACK) && i_wb_cyc;
  assign o_wb_rdt  = rdt_q;

endmodule

// File: tb/tb_wb_ram32_bridge.sv
// Scoreboard bench for wb_ram32_bridge driving a real ram32.
module tb_wb_ram32_bridge;

  localparam int RAM_SIZE = 1024;
  localparam int AW       = $clog2(RAM_SIZE / 4);

  logic          clk = 1'b0;
  logic          reset;
  logic          i_wb_cyc, i_wb_stb, i_wb_we;
  logic [31:0]   i_wb_adr, i_wb_dat;
  logic [3:0]    i_wb_sel;
  logic [31:0]   o_wb_rdt;
  logic          o_wb_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  wb_ram32_bridge #(.RAM_SIZE(RAM_SIZE)) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram32 #(.RAM_SIZE(RAM_SIZE)) u_ram (
    .clk(clk), .reset(reset), .addr(ram_addr), .we(ram_we),
    .data_in(ram_wdata), .data_out(ram_rdata)
  );

  typedef struct {
    int          issue;
    int          we_base;
    logic [31:0] rdt;
    int          lat;
    int          we_off;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0;
  int          cnt = 0, we_total = 0, last_we_cyc = -1;
  logic [31:0] rdt_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cnt);
    end
  endtask

  always @(posedge clk) cnt <= cnt + 1;

  // Monitor: count RAM write pulses, and score every acknowledge against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (ram_we) begin
      we_total++;
      last_we_cyc = cnt;
    end
    if (o_wb_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_latency", cnt - e.issue, e.lat);
        check("rdt", o_wb_rdt, e.rdt);
        if (e.we_off < 0) begin
          check("no_ram_we", we_total - e.we_base, 0);
        end else begin
          check("ram_we_count", we_total - e.we_base, 1);
          check("ram_we_cycle", last_we_cyc - e.issue, e.we_off);
        end
      end
    end
  end

  task automatic drive(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we  = we;
    i_wb_adr = adr;
    i_wb_dat = dat;
    i_wb_sel = sel;
  endtask

  task automatic idle_bus();
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
    i_wb_adr = '0;
    i_wb_dat = '0;
    i_wb_sel = '0;
  endtask

  // Writes expect o_wb_rdt to still hold the last read value.
  task automatic expect_item(input int lat, input int we_off, input bit is_read,
                             input logic [31:0] rd_val);
    exp_t e;
    if (is_read) rdt_model = rd_val;
    e.issue   = cnt;
    e.we_base = we_total;
    e.rdt     = rdt_model;
    e.lat     = lat;
    e.we_off  = we_off;
    sb.push_back(e);
  endtask

  task automatic wait_ack();
    bit seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      #1;
      seen = o_wb_ack;
    end
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                    input int lat, input int we_off);
    @(posedge clk);
    #1;
    drive(1'b1, adr, dat, sel);
    expect_item(lat, we_off, 1'b0, '0);
    wait_ack();
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp);
    @(posedge clk);
    #1;
    drive(1'b0, adr, 32'h0, 4'hF);
    expect_item(3, -1, 1'b1, exp);
    wait_ack();
  endtask

  task automatic abort_partial(input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel);
    int base;
    @(posedge clk);
    #1;
    drive(1'b1, adr, dat, sel);
    base = we_total;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    idle_bus();
    repeat (4) @(negedge clk);
    #1;
    check("abort_no_ram_we", we_total - base, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rdt_model = '0;
    reset = 1'b1;
    drive(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    repeat (3) begin
      @(negedge clk);
      check("reset_ack", {31'b0, o_wb_ack}, 32'd0);
      check("reset_ram_we", {31'b0, ram_we}, 32'd0);
      check("reset_rdt", o_wb_rdt, 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_item(2, 1, 1'b0, '0);
    wait_ack();

    rd(32'h10, 32'hDEADBEEF);

    wr(32'h20, 32'h11223344, 4'hF, 2, 1);
    wr(32'h20, 32'hAABBCCDD, 4'b0101, 4, 3);
    rd(32'h20, 32'h11BB33DD);

    wr(32'h30, 32'h55667788, 4'hF, 2, 1);
    wr(32'h30, 32'hFFFFFFFF, 4'h0, 1, -1);
    rd(32'h30, 32'h55667788);

    wr(32'h404, 32'h12345678, 4'hF, 2, 1);
    rd(32'h004, 32'h12345678);
    rd(32'h006, 32'h12345678);

    wr(32'h40, 32'hCAFEF00D, 4'hF, 2, 1);
    abort_partial(32'h40, 32'h00000000, 4'h3);
    rd(32'h40, 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_ram32_bridge.md
Name: wb_ram32_bridge

Overview:
Wishbone classic slave that fronts the 32-bit single-port, 1-cycle-latency on-chip RAM (ram32) for the SERV core's data bus. It translates byte-addressed Wishbone cycles into RAM word accesses. The RAM has no byte enables, so partial-word writes (sel != 4'hF) are done as an internal read-modify-write. It sits directly upstream of ram32 and drives its addr/we/data_in; it consumes data_out.

Parameters:
RAM_SIZE, 1024, RAM size in bytes; must match the attached ram32 instance
RAM_ADDR_BITS, $clog2(RAM_SIZE/4), localparam; RAM word-address width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
i_wb_cyc  input  1  Wishbone cycle
i_wb_stb  input  1  Wishbone strobe
i_wb_we  input  1  1 = write, 0 = read
i_wb_adr  input  32  byte address; bits [RAM_ADDR_BITS+1:2] used
i_wb_dat  input  32  write data
i_wb_sel  input  4  byte selects; bit n selects byte lane [8n+7:8n]
o_wb_rdt  output  32  read data, registered
o_wb_ack  output  1  single-cycle acknowledge
ram_addr  output  RAM_ADDR_BITS  to ram32 addr
ram_we  output  1  to ram32 we
ram_wdata  output  32  to ram32 data_in
ram_rdata  input  32  from ram32 data_out; valid the cycle after addr is presented with we=0

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset values: state=IDLE, o_wb_rdt=0, o_wb_ack=0, ram_we=0, ram_addr=0, ram_wdata=0. Latched request registers are cleared to 0.
- States: IDLE, READ, WAIT, WRITE, ACK. State is registered.
- RAM-side outputs are decoded from the state plus the latched request only; they never depend combinationally on Wishbone inputs.
- IDLE: on i_wb_cyc & i_wb_stb, latch adr[RAM_ADDR_BITS+1:2], dat, sel and we. Next state:
  - read, or write with sel not in {4'hF, 4'h0} -> READ
  - write with sel=4'hF -> WRITE
  - write with sel=4'h0 -> ACK; no RAM write
- READ: ram_addr=latched addr, ram_we=0 -> WAIT.
- WAIT: ram_rdata is valid.
  - Read: o_wb_rdt <= ram_rdata -> ACK.
  - Partial write: merge_reg <= per lane, sel[n] ? dat lane : ram_rdata lane -> WRITE.
- WRITE: ram_we=1, ram_addr=latched addr, ram_wdata = merge_reg (partial) or latched dat (full) -> ACK.
- ACK: o_wb_ack = i_wb_cyc. Exactly one cycle; always -> IDLE. A new request is accepted no earlier than the cycle after ACK.
- Latency, with the accept cycle = N: read ack in N+3; full write ack in N+2; partial write ack in N+4; sel=0 write ack in N+1.
- o_wb_rdt changes only in WAIT for reads; it holds its value across writes.
- Address aliasing: bits above RAM_ADDR_BITS+1 and bits [1:0] are ignored; no bus error is generated.
- Abort: if i_wb_cyc=0 in READ or WAIT -> IDLE; no ack, no RAM write, o_wb_rdt unchanged. WRITE always commits. In ACK with cyc=0, ack is suppressed and state -> IDLE.
- Inputs are ignored outside IDLE; the latched values are used.
- Reset mid-transaction: state -> IDLE, ram_we deasserts the same edge, and any pending write is dropped if still in READ or WAIT.
- ram32 returns 0 while in reset; the bridge never samples ram_rdata outside WAIT.

Decomposition:
- Shared package ram_bridge_pkg:
  - state enum typedef (IDLE, READ, WAIT, WRITE, ACK)
  - SEL_FULL = 4'hF constant
  - function byte_merge(old, new, sel), returning a 32-bit merged word
- No sub-module; byte_merge is a function. The testbench instantiates the bridge with a real ram32 (RAM_SIZE=1024).

Test Plan:
- Reset held 3 cycles with cyc/stb high -> no ack, ram_we=0, o_wb_rdt=0; after release, first accept happens the cycle after reset deasserts.
- Full write adr=0x10, dat=0xDEADBEEF, sel=F; then read adr=0x10 -> write ack at N+2, ram_we high only in N+1; read ack at N+3 with o_wb_rdt=0xDEADBEEF.
- Preload 0x11223344 at 0x20; write sel=4'b0101, dat=0xAABBCCDD; read back -> 0x11BB33DD; ram_we high exactly one cycle (N+3); ack at N+4.
- Write sel=0 to 0x30 holding 0x55667788 -> ack at N+1, no ram_we pulse; read returns 0x55667788.
- Aliasing: write 0x12345678 to adr=0x404 (RAM_SIZE=1024); read adr=0x004 -> 0x12345678. Read adr=0x006 -> same word.
- Abort: drop cyc in WAIT of a partial write to 0x40 -> no ack, no ram_we, mem[0x40>>2] unchanged. A following read completes normally with ack at N+3.
